// File: rtl/aes_enc_round_engine.sv
// Iterative AES-128 encryption engine: one cipher round per clock, external round-key store
// addressed by rk_idx, valid/ready handshakes on plaintext input and ciphertext output.

// Forward AES S-box built from the GF(2^8) inverse (x^254) followed by the affine transform.
module aesSbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gfMul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  always_comb begin
    x2   = gfMul(a, a);
    x3   = gfMul(x2, a);
    x6   = gfMul(x3, x3);
    x12  = gfMul(x6, x6);
    x15  = gfMul(x12, x3);
    x30  = gfMul(x15, x15);
    x60  = gfMul(x30, x30);
    x120 = gfMul(x60, x60);
    x240 = gfMul(x120, x120);
    x252 = gfMul(x240, x12);
    inv  = gfMul(x252, x2);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_enc_round_engine (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);
  localparam int unsigned NumBytes  = 16;
  localparam int unsigned RoundW    = 4;
  localparam int unsigned LastRound = 10;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} stateT;

  stateT               stQ, stD;
  logic [RoundW-1:0]   roundQ, roundD;
  logic [127:0]        stateQ, stateD;
  logic [127:0]        ctQ, ctD;
  logic                inReadyQ, inReadyD;
  logic                outValidQ, outValidD;
  logic                busyQ, busyD;
  logic [RoundW-1:0]   rkIdxQ, rkIdxD;

  logic [7:0]   stBytes [NumBytes];
  logic [7:0]   sbBytes [NumBytes];
  logic [7:0]   srBytes [NumBytes];
  logic [7:0]   mcBytes [NumBytes];
  logic [127:0] srWord, mcWord, roundOut;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Round datapath: SubBytes -> ShiftRows -> MixColumns, byte i at bits [127-8i -: 8]
  for (genvar i = 0; i < NumBytes; i++) begin : gBytes
    assign stBytes[i] = stateQ[127-8*i -: 8];
    aesSbox uSbox (.a(stBytes[i]), .s(sbBytes[i]));
    assign srBytes[i] = sbBytes[(i + 4*(i % 4)) % 16];
    assign srWord[127-8*i -: 8] = srBytes[i];
    assign mcWord[127-8*i -: 8] = mcBytes[i];
  end

  for (genvar c = 0; c < 4; c++) begin : gCols
    assign mcBytes[4*c]   = xtime(srBytes[4*c]) ^ xtime(srBytes[4*c+1]) ^ srBytes[4*c+1]
                            ^ srBytes[4*c+2] ^ srBytes[4*c+3];
    assign mcBytes[4*c+1] = srBytes[4*c] ^ xtime(srBytes[4*c+1]) ^ xtime(srBytes[4*c+2])
                            ^ srBytes[4*c+2] ^ srBytes[4*c+3];
    assign mcBytes[4*c+2] = srBytes[4*c] ^ srBytes[4*c+1] ^ xtime(srBytes[4*c+2])
                            ^ xtime(srBytes[4*c+3]) ^ srBytes[4*c+3];
    assign mcBytes[4*c+3] = xtime(srBytes[4*c]) ^ srBytes[4*c] ^ srBytes[4*c+1]
                            ^ srBytes[4*c+2] ^ xtime(srBytes[4*c+3]);
  end

  assign roundOut = ((roundQ == RoundW'(LastRound)) ? srWord : mcWord) ^ rk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stQ       <= IDLE;
      roundQ    <= '0;
      stateQ    <= '0;
      ctQ       <= '0;
      inReadyQ  <= 1'b0;
      outValidQ <= 1'b0;
      busyQ     <= 1'b0;
      rkIdxQ    <= '0;
    end else begin
      stQ       <= stD;
      roundQ    <= roundD;
      stateQ    <= stateD;
      ctQ       <= ctD;
      inReadyQ  <= inReadyD;
      outValidQ <= outValidD;
      busyQ     <= busyD;
      rkIdxQ    <= rkIdxD;
    end
  end

  // Next state; status outputs are decoded from the next state so they register cleanly
  always_comb begin
    stD    = stQ;
    roundD = roundQ;
    stateD = stateQ;
    ctD    = ctQ;
    case (stQ)
      IDLE: begin
        if (in_valid && inReadyQ) begin
          stateD = plaintext ^ rk;
          roundD = RoundW'(1);
          stD    = ROUND;
        end
      end
      ROUND: begin
        if (roundQ > RoundW'(LastRound)) begin
          roundD = '0;
          stD    = IDLE;
        end else begin
          stateD = roundOut;
          if (roundQ == RoundW'(LastRound)) begin
            ctD = roundOut;
            stD = DONE;
          end else begin
            roundD = RoundW'(roundQ + RoundW'(1));
          end
        end
      end
      DONE: begin
        if (out_ready) stD = IDLE;
      end
      default: stD = IDLE;
    endcase
    inReadyD  = (stD == IDLE);
    outValidD = (stD == DONE);
    busyD     = (stD != IDLE);
    rkIdxD    = (stD == ROUND) ? roundD : '0;
  end

  assign in_ready   = inReadyQ;
  assign out_valid  = outValidQ;
  assign busy       = busyQ;
  assign rk_idx     = rkIdxQ;
  assign ciphertext = ctQ;
endmodule

// File: tb/tb_aes_enc_round_engine.sv
// Directed bench for aes_enc_round_engine using FIPS-197 vectors and a table-based key schedule.
module tb_aes_enc_round_engine;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  int nChecks = 0;
  int nFail = 0;
  int cyc = 0;
  int acceptCyc [$];
  logic [127:0] rkTab [11];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  aes_enc_round_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy));

  always #5 clk = ~clk;

  // Combinational key store
  always_comb rk = (rk_idx <= 4'd10) ? rkTab[rk_idx] : 128'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acceptCyc.push_back(cyc);
  end

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic loadKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rkTab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one block from IDLE and follow it to DONE, checking every round cycle
  task automatic encryptOne(input string tag, input logic [127:0] key,
                            input logic [127:0] pt, input logic [127:0] exp, input bit disturb);
    loadKey(key);
    plaintext = pt;
    in_valid  = 1'b1;
    check({tag, "_in_ready_pre"}, 128'(in_ready), 128'd1);
    check({tag, "_rk_idx_0"}, 128'(rk_idx), 128'd0);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (disturb && k == 3) begin
        in_valid  = 1'b1;
        plaintext = ~pt;
      end
      if (disturb && k == 4) in_valid = 1'b0;
      check($sformatf("%s_rk_idx_%0d", tag, k), 128'(rk_idx), 128'(k));
      check($sformatf("%s_out_valid_lo_%0d", tag, k), 128'(out_valid), 128'd0);
      check($sformatf("%s_busy_%0d", tag, k), 128'(busy), 128'd1);
      check($sformatf("%s_in_ready_lo_%0d", tag, k), 128'(in_ready), 128'd0);
      step();
    end
    in_valid = 1'b0;
    check({tag, "_out_valid"}, 128'(out_valid), 128'd1);
    check({tag, "_ciphertext"}, ciphertext, exp);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_idle_in_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_idle_busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int a0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    loadKey(KEY_B);

    // Reset values
    step();
    step();
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'd0);
    check("rst_ciphertext", ciphertext, 128'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 128'(in_ready), 128'd1);

    // App. B with backpressure; in_valid pulses in DONE must be ignored
    encryptOne("appB", KEY_B, PT_B, CT_B, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      step();
      check($sformatf("bp_out_valid_%0d", i), 128'(out_valid), 128'd1);
      check($sformatf("bp_ciphertext_%0d", i), ciphertext, CT_B);
      check($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    handoff("bp");

    // App. C.1 with rk_idx sequence
    encryptOne("appC", KEY_C, PT_C, CT_C, 1'b0);
    handoff("appC");

    // Back-to-back with in_valid and out_ready held high
    loadKey(KEY_B);
    plaintext = PT_B;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a0 = acceptCyc.size();
    for (int i = 0; i < 11; i++) step();
    check("b2b_first_out_valid", 128'(out_valid), 128'd1);
    check("b2b_first_ct", ciphertext, CT_B);
    loadKey(KEY_C);
    plaintext = PT_C;
    step();
    check("b2b_handoff_busy", 128'(busy), 128'd0);
    check("b2b_handoff_out_valid", 128'(out_valid), 128'd0);
    check("b2b_handoff_in_ready", 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    check("b2b_second_accept_rk_idx", 128'(rk_idx), 128'd1);
    for (int i = 0; i < 10; i++) step();
    check("b2b_second_out_valid", 128'(out_valid), 128'd1);
    check("b2b_second_ct", ciphertext, CT_C);
    check("b2b_accept_count", 128'(acceptCyc.size() - a0), 128'd2);
    if (acceptCyc.size() - a0 == 2)
      check("b2b_spacing", 128'(acceptCyc[a0+1] - acceptCyc[a0]), 128'd12);
    step();
    out_ready = 1'b0;
    check("b2b_end_in_ready", 128'(in_ready), 128'd1);

    // Asynchronous reset at round 5
    loadKey(KEY_B);
    plaintext = PT_B;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_rk_idx_5", 128'(rk_idx), 128'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(in_ready), 128'd0);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_rk_idx", 128'(rk_idx), 128'd0);
    check("mid_rst_ciphertext", ciphertext, 128'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("mid_no_out_valid_%0d", i), 128'(out_valid), 128'd0);
    end

    // Fresh App. B with in_valid/plaintext disturbed during ROUND
    encryptOne("appB_dist", KEY_B, PT_B, CT_B, 1'b1);
    handoff("appB_dist");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
